// File: rtl/codegen_pkg.sv
// -----------------------------------------------------------------------------
// codegen_pkg
// Shared definitions for the code-generator scheduler:
//   - default widths for the code counter, output word and burst length
//   - burst FSM state enum
//   - requester index type and a one-hot to index helper
// -----------------------------------------------------------------------------
package codegen_pkg;

   localparam int unsigned CNT_W_DEF  = 16;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned LEN_W_DEF  = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Two requesters, so one bit identifies either of them.
   typedef logic req_idx_t;

   // Index of the asserted bit in a two-bit one-hot grant.
   function automatic req_idx_t onehot_to_idx(input logic [1:0] oh);
      return req_idx_t'(oh[1]);
   endfunction

endpackage : codegen_pkg

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. A lone requester always wins; when both
// request, the holder of the priority pointer wins. When advance is high
// and a grant is produced, the pointer moves to the requester that lost.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (pointer -> requester 0)
//   req      in   [1:0] request vector
//   advance  in   commit the current grant and update the pointer
//   gnt      out  [1:0] combinational one-hot grant (0 when req == 0)
// -----------------------------------------------------------------------------
module rr_arb2
   import codegen_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   req_idx_t ptr_q;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt = 2'b00;
      unique case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (ptr_q == 1'b1) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering in simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         // Priority goes to the requester that did not win this time.
         ptr_q <= req_idx_t'(~onehot_to_idx(gnt));
      end
   end

endmodule : rr_arb2

// File: rtl/codegen_sched.sv
// -----------------------------------------------------------------------------
// codegen_sched
// Burst scheduler for a sequential code generator. Two requesters compete
// (round-robin) for a burst; the winner's seed and length are captured and
// the block streams seed, seed+1, ... (modulo 2^CNT_W) over a valid/ready
// interface until len+1 words have been accepted or abort is raised.
//
// Parameters:
//   CNT_W   code counter width
//   DATA_W  output word width (>= CNT_W), code is zero-extended
//   LEN_W   burst length field width (field holds length minus one)
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   req         in   [1:0] level requests, held until granted
//   len0/len1   in   burst length minus one, per requester
//   seed0/seed1 in   first code of the burst, per requester
//   abort       in   terminate the active burst
//   gnt         out  [1:0] one-cycle one-hot grant pulse
//   busy        out  burst active
//   out_valid   out  code word valid
//   out_ready   in   consumer accepts the word
//   out_data    out  zero-extended code word
//   out_owner   out  requester owning the current burst
//   out_last    out  final word of the burst
//   stat_words  out  [31:0] handshaked-word counter, only present when the
//                    macro CODEGEN_SCHED_STATS_EN is defined
// -----------------------------------------------------------------------------
module codegen_sched
   import codegen_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [LEN_W-1:0]  len0,
   input  logic [LEN_W-1:0]  len1,
   input  logic [CNT_W-1:0]  seed0,
   input  logic [CNT_W-1:0]  seed1,
   input  logic              abort,
   output logic [1:0]        gnt,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_owner,
   output logic              out_last
`ifdef CODEGEN_SCHED_STATS_EN
   ,
   output logic [31:0]       stat_words
`endif
);

   state_t           state_q;
   state_t           state_d;
   logic [1:0]       arb_gnt;
   logic             start;
   logic             handshake;
   logic             rem_zero;
   req_idx_t         win_idx;
   req_idx_t         owner_q;
   logic [CNT_W-1:0] cnt_q;
   logic [LEN_W-1:0] rem_q;
   logic [1:0]       gnt_q;

   // ---------------------------------------------------------------------
   // Arbitration: only consulted in IDLE, so requests during a burst are
   // ignored and there is always at least one idle cycle between bursts.
   // ---------------------------------------------------------------------
   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .advance (start),
      .gnt     (arb_gnt)
   );

   assign win_idx   = onehot_to_idx(arb_gnt);
   assign handshake = (state_q == ST_BURST) && out_ready;
   assign rem_zero  = (rem_q == '0);

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next state and burst start strobe
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // abort has no meaning here and must not suppress a grant.
            if (req != 2'b00) begin
               state_d = ST_BURST;
               start   = 1'b1;
            end
         end
         ST_BURST: begin
            // A word handshaked together with abort still counts; the burst
            // simply ends after it.
            if (abort || (handshake && rem_zero)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: captured burst parameters, code counter, grant pulse
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         rem_q   <= '0;
         owner_q <= 1'b0;
         gnt_q   <= 2'b00;
      end else begin
         gnt_q <= start ? arb_gnt : 2'b00;
         if (start) begin
            cnt_q   <= (win_idx == 1'b1) ? seed1 : seed0;
            rem_q   <= (win_idx == 1'b1) ? len1  : len0;
            owner_q <= win_idx;
         end else if (handshake) begin
            // Counter wraps naturally at 2^CNT_W.
            cnt_q <= cnt_q + 1'b1;
            if (!rem_zero) begin
               rem_q <= rem_q - 1'b1;
            end
         end
      end
   end

`ifdef CODEGEN_SCHED_STATS_EN
   logic [31:0] stat_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_q <= '0;
      end else if (handshake) begin
         stat_q <= stat_q + 32'd1;
      end
   end

   assign stat_words = stat_q;
`endif

   // ---------------------------------------------------------------------
   // Outputs: all derived from registers, so they hold steady during stalls.
   // ---------------------------------------------------------------------
   assign busy      = (state_q == ST_BURST);
   assign out_valid = (state_q == ST_BURST);
   assign out_last  = (state_q == ST_BURST) && rem_zero;
   assign out_data  = DATA_W'(cnt_q);
   assign out_owner = owner_q;
   assign gnt       = gnt_q;

endmodule : codegen_sched

// File: doc/codegen_sched.md
CODEGEN_SCHED -- requirements
Module: codegen_sched

Interface
- REQ-001: Parameter CNT_W, default 16, code counter width.
- REQ-002: Parameter DATA_W, default 32, output word width; SHALL be >= CNT_W.
- REQ-003: Parameter LEN_W, default 8, burst length field width.
- REQ-004: clk  in  1  single clock; all logic on rising edge.
- REQ-005: rst  in  1  synchronous, active-high reset.
- REQ-006: req  in  2  per-requester burst request, level, held until granted.
- REQ-007: len0, len1  in  LEN_W each  burst length minus one (0 = 1 word, 255 = 256 words).
- REQ-008: seed0, seed1  in  CNT_W each  first code value of the burst.
- REQ-009: abort  in  1  terminate active burst.
- REQ-010: gnt  out  2  one-hot, one-cycle grant pulse.
- REQ-011: busy  out  1  high while a burst is active.
- REQ-012: out_valid  out  1  code word valid.
- REQ-013: out_ready  in  1  consumer accepts word.
- REQ-014: out_data  out  DATA_W  zero-extended code, {zeros, cnt}.
- REQ-015: out_owner  out  1  index of the requester owning the current burst.
- REQ-016: out_last  out  1  final word of the burst.

Function
- REQ-017: FSM states IDLE and BURST only; out_valid and busy SHALL equal (state == BURST).
- REQ-018: IDLE with req != 0 at edge t: the winner's len/seed are captured, state = BURST, gnt[winner] = 1 for exactly the cycle after t, out_valid = 1 from that same cycle.
- REQ-019: Arbitration is round-robin: a priority pointer SHALL point to the non-winner after each grant; on a tie the pointer holder wins; a single requester always wins.
- REQ-020: req during BURST SHALL be ignored; arbitration resumes only in IDLE, which gives a minimum one-cycle gap between bursts.
- REQ-021: Word handshake = out_valid & out_ready; on each handshake cnt increments modulo 2^CNT_W (0xFFFF -> 0x0000) and the remaining count decrements.
- REQ-022: out_data, out_owner and out_last SHALL stay stable while out_valid & !out_ready.
- REQ-023: out_last = 1 iff remaining == 0; a handshake with out_last high SHALL return the FSM to IDLE on the next cycle.
- REQ-024: abort in BURST -> IDLE on the next cycle, with no further words; if a handshake occurs in the same cycle, that word counts as transferred.
- REQ-025: abort in IDLE SHALL have no effect and SHALL NOT block a grant in the same cycle.

Reset
- REQ-026: rst high at an edge -> state IDLE, cnt 0, remaining 0, pointer = requester 0, gnt 0, busy 0, out_valid 0, out_last 0, out_owner 0, out_data 0.
- REQ-027: rst mid-burst SHALL discard the burst with no further out_valid and no grant pulse; rst takes precedence over abort and req.

Configuration
- REQ-028: Macro CODEGEN_SCHED_STATS_EN defined -> extra output stat_words (32 bits) counting all handshaked words, wrapping, cleared by rst.
- REQ-029: Macro undefined -> the stat_words port and its counter SHALL be absent; all other behaviour is identical.

Structure
- REQ-030: Package codegen_pkg SHALL hold the FSM state enum, the default CNT_W/DATA_W/LEN_W constants, and the requester index type.
- REQ-031: Arbitration SHALL live in sub-module rr_arb2 (req[1:0], advance -> one-hot grant, internal pointer); the top-level block holds the FSM, counter and datapath.

Verification
- REQ-032: req=01, len0=3, seed0=0x0010, out_ready=1 -> gnt=01 one cycle; data 0x10,0x11,0x12,0x13 on consecutive cycles; out_last on 0x13; busy low the cycle after.
- REQ-033: req=11 held from reset -> grants alternate: 01, 10, 01, 10, with one IDLE cycle between bursts.
- REQ-034: seed=0xFFFE, len=2 -> data 0x0000FFFE, 0x0000FFFF, 0x00000000.
- REQ-035: out_ready toggling 1,0,0,1 mid-burst -> out_data held during stall cycles, no word skipped or duplicated.
- REQ-036: abort on the 2nd word of a len=9 burst with ready=1 -> 2 words transferred, IDLE the next cycle; rst on the 3rd word of a new burst -> all outputs 0 the next cycle.
- REQ-037: With CODEGEN_SCHED_STATS_EN defined, the REQ-032 and REQ-034 sequences -> stat_words = 7.
